// File: rtl/aquant_vec.sv
// aquant_vec: per-channel scale / shift / zero-point / saturate / threshold quantiser
// for LANES accumulator results per beat, one channel per beat, 4 arithmetic stages.
`timescale 1ns/1ps
module aquant_vec #(
  parameter int DW_OFM = 32,
  parameter int LANES  = 4,
  parameter int NUM_CH = 16,
  parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CW-1:0]           cfg_addr,
  input  logic [15:0]             cfg_s,
  input  logic [3:0]              cfg_r,
  input  logic [7:0]              cfg_c,
  input  logic [7:0]              cfg_t,
  input  logic [CW:0]             cfg_nch,
  input  logic                    rnd_en,
  input  logic                    ch_clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DW_OFM-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*8-1:0]      out_data,
  output logic [CW-1:0]           out_ch
);
  localparam int AW = 48;
  logic signed [15:0] s_tab [NUM_CH];
  logic [3:0] r_tab [NUM_CH];
  logic [7:0] c_tab [NUM_CH];
  logic [7:0] t_tab [NUM_CH];
  logic [CW-1:0] ch_ptr, ch0, ch1, ch2, ch3;
  logic [CW:0] nch_eff;
  logic en, acc, v0, v1, v2, v3;
  logic signed [DW_OFM-1:0] d0 [LANES];
  logic signed [15:0] s0;
  logic [3:0] r0, r1;
  logic [7:0] c0, c1, c2, t0, t1, t2, t3, q;
  logic signed [AW-1:0] p1 [LANES];
  logic signed [AW-1:0] p2 [LANES];
  logic signed [AW-1:0] p3 [LANES];
  logic signed [AW-1:0] bias;
  logic [LANES*8-1:0] od;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign acc      = in_valid && en;
  assign nch_eff  = (cfg_nch == '0) ? (CW+1)'(1) :
                    (cfg_nch > (CW+1)'(NUM_CH)) ? (CW+1)'(NUM_CH) : cfg_nch;
  assign bias     = (rnd_en && r1 != 4'd0) ? AW'(1) << (r1 - 4'd1) : '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        s_tab[i] <= 16'sd1;
        r_tab[i] <= '0;
        c_tab[i] <= '0;
        t_tab[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CH; i++)
        if (32'(cfg_addr) == i) begin
          s_tab[i] <= cfg_s;
          r_tab[i] <= cfg_r;
          c_tab[i] <= cfg_c;
          t_tab[i] <= cfg_t;
        end
    end

  // the >= test also wraps immediately when cfg_nch drops below the pointer
  always_ff @(posedge clk or posedge rst)
    if (rst) ch_ptr <= '0;
    else if (ch_clr) ch_ptr <= '0;
    else if (acc) ch_ptr <= ({1'b0, ch_ptr} + 1'b1 >= nch_eff) ? '0 : ch_ptr + 1'b1;

  always_comb begin
    od = '0;
    q  = '0;
    for (int i = 0; i < LANES; i++) begin
      q = (p3[i] < 48'sd0) ? 8'd0 : (p3[i] > 48'sd255) ? 8'd255 : p3[i][7:0];
      od[i*8 +: 8] = (q >= t3) ? q : t3;
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {v0, v1, v2, v3, out_valid} <= '0;
      out_data <= '0;
      out_ch <= '0;
      {ch0, ch1, ch2, ch3} <= '0;
      s0 <= '0;
      {r0, r1} <= '0;
      {c0, c1, c2, t0, t1, t2, t3} <= '0;
      for (int i = 0; i < LANES; i++) begin
        d0[i] <= '0;
        p1[i] <= '0;
        p2[i] <= '0;
        p3[i] <= '0;
      end
    end else if (en) begin
      {v0, v1, v2, v3, out_valid} <= {acc, v0, v1, v2, v3};
      s0 <= s_tab[ch_ptr];
      r0 <= r_tab[ch_ptr];
      c0 <= c_tab[ch_ptr];
      t0 <= t_tab[ch_ptr];
      ch0 <= ch_ptr;
      {r1, c1, t1, ch1} <= {r0, c0, t0, ch0};
      {c2, t2, ch2} <= {c1, t1, ch1};
      {t3, ch3} <= {t2, ch2};
      out_ch <= ch3;
      out_data <= od;
      for (int i = 0; i < LANES; i++) begin
        d0[i] <= in_data[i*DW_OFM +: DW_OFM];
        p1[i] <= AW'(s0) * AW'(d0[i]);
        p2[i] <= (p1[i] + bias) >>> r1;
        p3[i] <= p2[i] + AW'(c2);
      end
    end
endmodule

// File: doc/aquant_vec.md
# aquant_vec

Vectorised, per-channel activation/quantisation unit. Takes `LANES` signed `DW_OFM`-bit accumulator results per beat and turns each into an unsigned 8-bit activation:

- multiply by a per-channel scale;
- arithmetic right shift, with optional round-half-up;
- add the zero point;
- saturate to 0..255;
- floor at a per-channel threshold.

It sits between the PE array's output-feature-map drain and the activation write-back buffer. It has a 4-stage valid/ready pipeline and a channel pointer that advances by one each beat, so consecutive beats map to consecutive output channels.

## Interface

Parameters:
- `DW_OFM`, 32: width of each input lane (signed).
- `LANES`, 4: pixels per beat. All lanes in a beat share one channel.
- `NUM_CH`, 16: depth of the per-channel parameter table.
- `CW`, `$clog2(NUM_CH)`: width of channel indices. Minimum 1.

Ports:
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `cfg_we` input 1: write the parameter table entry at `cfg_addr`.
- `cfg_addr` input CW: table index. Writes with `cfg_addr >= NUM_CH` are ignored.
- `cfg_s` input 16: signed scale.
- `cfg_r` input 4: right-shift amount, 0..15.
- `cfg_c` input 8: unsigned zero point.
- `cfg_t` input 8: unsigned threshold floor.
- `cfg_nch` input CW+1: number of active channels.
  - Value 0 is treated as 1.
  - Values above `NUM_CH` are treated as `NUM_CH`.
- `rnd_en` input 1: 1 = round-half-up before the shift; 0 = truncate (floor).
- `ch_clr` input 1: synchronous clear of the channel pointer to 0.
- `in_valid` input 1; `in_ready` output 1; `in_data` input LANES*DW_OFM. Lane i is bits [i*DW_OFM +: DW_OFM].
- `out_valid` output 1; `out_ready` input 1; `out_data` output LANES*8. Lane i is bits [i*8 +: 8].
- `out_ch` output CW: channel index of the beat on `out_data`.

## Operation

- **Parameter table:** `NUM_CH` register entries {s, r, C, T}.
  - Reset value of every entry: s=1, r=0, C=0, T=0.
  - Writes complete at the clock edge.
- **Channel pointer `ch_ptr`:**
  - Resets to 0.
  - On each accepted beat (`in_valid && in_ready`), it takes `ch_ptr+1`, wrapping to 0 after the effective `cfg_nch`-1.
  - `ch_clr` forces it to 0 and takes priority over the increment. A beat accepted in the same cycle as `ch_clr` still uses the old `ch_ptr`.
- **Parameter capture:** the parameters are read at acceptance, from entry `ch_ptr`, and travel down the pipeline with the beat.
  - A `cfg_we` to the same entry in the same cycle is not seen by that beat; the beat uses the old value.
- **Arithmetic, per lane, 48-bit signed intermediate:**
  - Stage 1: `p1 = s * din`, full-width signed product.
  - Stage 2: `p2 = (p1 + bias) >>> r`.
    - `bias = 1 << (r-1)` when `rnd_en` is set and r > 0; otherwise `bias = 0`.
    - `rnd_en` is sampled when the beat enters stage 2.
  - Stage 3: `p3 = p2 + C`, with C zero-extended.
  - Stage 4: `q = sat(p3)`, where sat gives 0 if p3 < 0, 255 if p3 > 255, otherwise p3.
    - Output is `q` if `q >= T`, otherwise `T`.
- **Flow control:** one global enable, `en = !out_valid || out_ready`.
  - `in_ready = en`.
  - All stage registers and their valid bits advance only when `en` is 1.
  - Beats are never dropped or duplicated.
  - Bubbles propagate; the pipeline does not compact them.
- **Configuration changes mid-stream:** `cfg_nch` and `rnd_en` are level inputs. Changing `cfg_nch` to a value below the current `ch_ptr` makes the next increment wrap to 0.

## Timing

- **Latency:** 4 cycles. A beat accepted at edge k appears with `out_valid`=1 after edge k+4, provided no stall occurs.
- **Throughput:** 1 beat per cycle while `out_ready` is held at 1.
- **Stall behaviour:** with `out_valid`=1 and `out_ready`=0, `out_data`, `out_ch` and `out_valid` hold stable until the beat is taken.
- **Reset values:**
  - Asserting `rst` at any time clears all stage valid bits and `ch_ptr`, and restores the table reset values.
  - After reset: `out_valid`=0, `out_data`=0, `out_ch`=0, and `in_ready`=1.
  - In-flight beats are discarded.
- **Outputs are registered.** `in_ready` is combinational from `out_valid` and `out_ready` only.

## Test plan

- **Identity and saturation.** Reset table (s=1, r=0, C=0, T=0). Lanes {100, -5, 300, 255} -> `out_data` lanes {100, 0, 255, 255}, `out_valid` 4 cycles after acceptance.
- **Rounding.** Channel 0 set to s=3, r=2, C=10, T=0.
  - Lanes {7, 6, -7, 0} with `rnd_en`=0 -> {15, 14, 4, 10}.
  - Same lanes with `rnd_en`=1 -> {15, 15, 5, 10}.
- **Threshold and large values.**
  - s=3, r=2, C=10, T=20, lane 7 -> 20.
  - s=-32768, r=0, lane 0x7FFFFFFF -> 0 (large negative product, no wrap).
  - s=32767, lane 0x7FFFFFFF -> 255.
- **Channel walk.** `cfg_nch`=3, channels 0/1/2 given C=1/2/3 with s=1, r=0, T=0. Seven beats of zeros -> `out_ch` 0,1,2,0,1,2,0 and data 1,2,3,1,2,3,1.
  - `ch_clr` asserted on beat 2's acceptance -> beat 2 still uses channel 2, and beat 3 uses channel 0.
- **Backpressure.** Continuous `in_valid`; `out_ready` toggles in a pseudo-random pattern, including low for 5 consecutive cycles. A scoreboard checks exact in-order output with no loss or duplication, and that `out_data` is stable while stalled.
- **Reset and write hazards.**
  - `rst` pulsed with 3 beats in flight -> `out_valid`=0 immediately, no stale beat emerges, `ch_ptr`=0.
  - `cfg_we` to the current channel on the accepting cycle -> that beat uses the old parameters and the next beat on that channel uses the new ones.
